bitwise_arb_ctrl: RTL and testbench

- Two-requester controller that shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT) between independent requesters, e.g. the integer issue path and the address/flag helper path.
- Accepts operations through valid/ready handshakes and arbitrates round-robin.
- Sequences each operation through latch, execute and respond phases, then returns the result with a backpressure-capable response handshake routed to the granted requester.

---
 rtl/bitwise_arb_ctrl.sv | 142 ++++++++++++++
 tb/tb_bitwise_arb_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_arb_ctrl.sv
// bitwise_arb_ctrl
// Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT A) between two
// requesters. Requests arrive on valid/ready handshakes and are arbitrated
// round-robin. Each accepted operation is latched, then executed, then
// answered through a response handshake that supports backpressure.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (0/1)
//   reqN_a/b                 operands; B is ignored by NOT
//   reqN_funct               00 AND, 01 OR, 10 XOR, 11 NOT A
//   rspN_valid               result is available for requester N
//   rsp_ready                shared consume strobe for whichever rspN_valid is high
//   rsp_data                 registered result
//   busy                     controller is not idle
//   rsp_zero                 (only with BITWISE_ARB_ZFLAG_EN) result is all zeros
//
// Optional feature macro: BITWISE_ARB_ZFLAG_EN
module bitwise_arb_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_funct,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_funct,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef BITWISE_ARB_ZFLAG_EN
  ,
  output logic             rsp_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             ptr;       // 0: requester 0 wins a tie, 1: requester 1 wins
  logic             owner;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       funct_q;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] lu_out;

  // Arbiter: a lone requester always wins; on a tie the pointer decides.
  // Requests are only granted in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = (state == IDLE) && !rst && req0_valid && (!req1_valid || !ptr);
    grant1 = (state == IDLE) && !rst && req1_valid && (!req0_valid ||  ptr);
    accept = grant0 || grant1;
  end

  // Logic unit, driven only by the latched operation.
  always_comb begin
    // NOTE: combinational blocks assign a default first so no path leaves
    // lu_out unassigned, which would infer a latch.
    lu_out = '0;
    unique case (funct_q)
      2'b00:   lu_out = a_q & b_q;
      2'b01:   lu_out = a_q | b_q;
      2'b10:   lu_out = a_q ^ b_q;
      default: lu_out = ~a_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = EXEC;
      EXEC:                   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) &&  owner;
    busy       = (state != IDLE);
  end

  // Datapath: operation latch on accept, result capture in EXEC. rsp_data
  // only changes in EXEC, so it stays stable for the whole RESP phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      funct_q  <= '0;
      rsp_data <= '0;
`ifdef BITWISE_ARB_ZFLAG_EN
      rsp_zero <= 1'b0;
`endif
    end else begin
      if (accept) begin
        owner   <= grant1;
        ptr     <= grant0;   // the requester just served loses the next tie
        a_q     <= grant1 ? req1_a     : req0_a;
        b_q     <= grant1 ? req1_b     : req0_b;
        funct_q <= grant1 ? req1_funct : req0_funct;
      end
      if (state == EXEC) begin
        rsp_data <= lu_out;
`ifdef BITWISE_ARB_ZFLAG_EN
        rsp_zero <= (lu_out == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_bitwise_arb_ctrl.sv
// Self-checking bench for bitwise_arb_ctrl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_bitwise_arb_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_funct, req1_funct;
  logic         rsp0_valid, rsp1_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         busy;
`ifdef BITWISE_ARB_ZFLAG_EN
  logic         rsp_zero;
`endif

  bitwise_arb_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_funct (req0_funct),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_funct (req1_funct),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy)
`ifdef BITWISE_ARB_ZFLAG_EN
    ,
    .rsp_zero   (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: m_age counts cycles since acceptance
  // (0 = nothing in flight, 1 = executing, 2 = answer offered).
  int           m_age   = 0;
  bit           m_ptr   = 1'b0;  // requester preferred on a tie
  bit           m_owner = 1'b0;
  logic [W-1:0] m_res   = '0;
  logic [W-1:0] m_data  = '0;
  bit           m_zero  = 1'b0;

  // Observed values from the most recent step.
  logic         o_r0, o_r1, o_v0, o_v1, o_busy;
  logic [W-1:0] o_data;

  function automatic logic [W-1:0] ref_op(input logic [1:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (f)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare after settling,
  // then advance the model to what the coming rising edge must produce.
  task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [1:0] f0, input bit v1, input logic [W-1:0] a1,
                      input logic [W-1:0] b1, input logic [1:0] f1, input bit rr, input bit r);
    bit e_r0, e_r1;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_funct = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_funct = f1;
    rsp_ready  = rr; rst = r;
    #1;
    e_r0 = (m_age == 0) && !r && v0 && (!v1 || !m_ptr);
    e_r1 = (m_age == 0) && !r && v1 && (!v0 ||  m_ptr);
    o_r0 = req0_ready; o_r1 = req1_ready; o_v0 = rsp0_valid; o_v1 = rsp1_valid;
    o_busy = busy; o_data = rsp_data;
    check("req0_ready", 32'(o_r0), 32'(e_r0));
    check("req1_ready", 32'(o_r1), 32'(e_r1));
    check("rsp0_valid", 32'(o_v0), 32'((m_age == 2) && !m_owner));
    check("rsp1_valid", 32'(o_v1), 32'((m_age == 2) &&  m_owner));
    check("busy", 32'(o_busy), 32'(m_age != 0));
    check("rsp_data", 32'(o_data), 32'(m_data));
`ifdef BITWISE_ARB_ZFLAG_EN
    check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
`endif
    if (r) begin
      m_age = 0; m_ptr = 1'b0; m_owner = 1'b0; m_data = '0; m_zero = 1'b0;
    end else if (m_age == 0) begin
      if (e_r0 || e_r1) begin
        m_owner = e_r1;
        m_ptr   = !e_r1;
        m_res   = e_r1 ? ref_op(f1, a1, b1) : ref_op(f0, a0, b0);
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_data = m_res;
      m_zero = (m_res == '0);
      m_age  = 2;
    end else if (rr) begin
      m_age = 0;
    end
  endtask

  task automatic nop(input bit rr, input bit r);
    step(1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, rr, r);
  endtask

  logic [W-1:0] xa, xb, oa, ob;

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_funct = '0;
    req1_a = '0; req1_b = '0; req1_funct = '0;

    nop(1'b0, 1'b1);
    nop(1'b0, 1'b1);
    nop(1'b0, 1'b0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);

    // Single AND op from requester 0.
    step(1'b1, 16'hF0F0, 16'h0FF0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    check("single_ready0", 32'(o_r0), 32'd1);
    nop(1'b1, 1'b0);  // rsp_ready during execution has no effect
    check("single_exec_v0", 32'(o_v0), 32'd0);
    nop(1'b1, 1'b0);
    check("single_rsp0", 32'(o_v0), 32'd1);
    check("single_data", 32'(o_data), 32'h00F0);
    check("single_rsp1", 32'(o_v1), 32'd0);

    // Contention after reset: 0, then 1, then 0 again.
    nop(1'b0, 1'b1);
    xa = 16'hAAAA; xb = 16'hFFFF; oa = 16'h1200; ob = 16'h0034;
    step(1'b1, xa, xb, 2'd2, 1'b1, oa, ob, 2'd1, 1'b0, 1'b0);
    check("cont_first0", 32'(o_r0), 32'd1);
    check("cont_first1", 32'(o_r1), 32'd0);
    step(1'b1, xa, xb, 2'd2, 1'b1, oa, ob, 2'd1, 1'b1, 1'b0);
    step(1'b1, xa, xb, 2'd2, 1'b1, oa, ob, 2'd1, 1'b1, 1'b0);
    check("cont_rsp0_data", 32'(o_data), 32'h5555);
    step(1'b1, xa, xb, 2'd2, 1'b1, oa, ob, 2'd1, 1'b0, 1'b0);
    check("cont_second1", 32'(o_r1), 32'd1);
    check("cont_second0", 32'(o_r0), 32'd0);
    step(1'b1, xa, xb, 2'd2, 1'b1, oa, ob, 2'd1, 1'b0, 1'b0);
    step(1'b1, xa, xb, 2'd2, 1'b1, oa, ob, 2'd1, 1'b1, 1'b0);
    check("cont_rsp1", 32'(o_v1), 32'd1);
    check("cont_rsp1_data", 32'(o_data), 32'h1234);
    step(1'b1, xa, xb, 2'd2, 1'b1, oa, ob, 2'd1, 1'b0, 1'b0);
    check("cont_third0", 32'(o_r0), 32'd1);

    // Backpressure on the XOR result while requester 1 waits with a NOT op.
    step(1'b1, xa, xb, 2'd2, 1'b1, 16'h00FF, 16'h1234, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, xa, xb, 2'd2, 1'b1, 16'h00FF, 16'h1234, 2'd3, 1'b0, 1'b0);
      check("bp_ready1", 32'(o_r1), 32'd0);
      check("bp_data", 32'(o_data), 32'h5555);
    end
    step(1'b0, xa, xb, 2'd2, 1'b1, 16'h00FF, 16'h1234, 2'd3, 1'b1, 1'b0);
    check("bp_hs_ready1", 32'(o_r1), 32'd0);
    step(1'b0, xa, xb, 2'd2, 1'b1, 16'h00FF, 16'h1234, 2'd3, 1'b0, 1'b0);
    check("bp_grant1", 32'(o_r1), 32'd1);
    nop(1'b0, 1'b0);
    nop(1'b1, 1'b0);
    check("not_data", 32'(o_data), 32'hFF00);

    // Reset during execution discards the op and clears the pointer.
    step(1'b1, 16'h1111, 16'h2222, 2'd1, 1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    nop(1'b1, 1'b1);
    nop(1'b1, 1'b0);
    check("rmid_busy", 32'(o_busy), 32'd0);
    check("rmid_data", 32'(o_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nop(1'b1, 1'b0);
      check("rmid_no_rsp", 32'({o_v0, o_v1}), 32'd0);
    end
    step(1'b1, 16'h0F0F, 16'h00FF, 2'd0, 1'b1, 16'h1, 16'h2, 2'd2, 1'b0, 1'b0);
    check("rmid_ptr0", 32'(o_r0), 32'd1);
    nop(1'b0, 1'b0);
    nop(1'b1, 1'b0);

`ifdef BITWISE_ARB_ZFLAG_EN
    step(1'b1, 16'hFF00, 16'h00FF, 2'd0, 1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
    nop(1'b0, 1'b0);
    nop(1'b1, 1'b0);
    check("zf_and_zero", 32'(rsp_zero), 32'd1);
    check("zf_and_data", 32'(o_data), 32'd0);
    step(1'b0, '0, '0, 2'd0, 1'b1, 16'hFF00, 16'h00FF, 2'd1, 1'b0, 1'b0);
    nop(1'b0, 1'b0);
    nop(1'b1, 1'b0);
    check("zf_or_zero", 32'(rsp_zero), 32'd0);
    check("zf_or_data", 32'(o_data), 32'hFFFF);
`endif

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 3) != 0, W'($urandom), W'($urandom), 2'($urandom),
           ($urandom % 3) != 0, W'($urandom), W'($urandom), 2'($urandom),
           ($urandom % 2) == 0, ($urandom % 64) == 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
